mic_pdm_capture: RTL
====================

MIC_PDM_CAPTURE -- requirements
Module: mic_pdm_capture

Interface
REQ-001 Parameter CLK_DIV, default 25: clk cycles per mclk half-period, legal range 2..255.
REQ-002 Parameter DW, default 8: bits per packed FIFO word.
REQ-003 clk  in  1  system clock, the only clock; all logic on its rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 enable  in  1  capture enable, level-sensitive.
REQ-006 mclk  out  1  microphone bit clock, 50% duty, period 2*CLK_DIV clk cycles.
REQ-007 micData  in  1  PDM bit stream from the microphone, asynchronous to clk.
REQ-008 din  out  DW  packed sample word toward the FIFO write port.
REQ-009 wr_en  out  1  one-cycle FIFO write strobe; din is valid only while wr_en=1.
REQ-010 full  in  1  FIFO full flag, sampled in the same cycle as wr_en.
REQ-011 overflow  out  1  sticky flag: at least one word was dropped since reset.
REQ-012 ovf_cnt  out  8  count of dropped words, saturating at 255.
REQ-013 ledres  out  1  equals overflow, for board LED.

Function
REQ-014 Two states, IDLE and RUN; IDLE->RUN when enable=1; RUN->IDLE when enable=0, taken at the next mclk falling edge.
REQ-015 IDLE: mclk=0, divider=0, bit counter=0, shift register holds its value, wr_en=0.
REQ-016 RUN: divider counts 0..CLK_DIV-1; at terminal count mclk toggles and divider wraps to 0.
REQ-017 micData passes through a 2-flop synchronizer; only the synchronized value is used.
REQ-018 Sample strobe is the clk cycle in which mclk toggles 1->0; the synchronized bit shifts in at the LSB (first bit ends up as MSB).
REQ-019 Bit counter counts 0..DW-1; on the strobe with count DW-1, {shift[DW-2:0], bit} is presented on din with wr_en=1 in the next cycle, and the counter wraps to 0.
REQ-020 wr_en is exactly one clk wide; there is at most one pulse per DW mclk periods.
REQ-021 full=1 in the wr_en cycle: wr_en is suppressed to 0, the word is dropped, overflow is set, and ovf_cnt increments unless already 255.
REQ-022 full=0: normal write; overflow and ovf_cnt are unchanged.
REQ-023 enable falling mid-word: the partial word is discarded, no wr_en is issued, the bit counter clears, and mclk is left at 0.
REQ-024 enable re-asserted: capture restarts with bit counter 0; the first word is complete after DW full mclk periods.
REQ-025 overflow and ovf_cnt are cleared only by reset; they persist across enable toggles.

Reset
REQ-026 Asserting reset asynchronously forces: state=IDLE, mclk=0, wr_en=0, din=0, overflow=0, ovf_cnt=0, divider=0, bit counter=0, synchronizer=0.
REQ-027 Reset asserted mid-word: the partial word is lost and no wr_en is issued.
REQ-028 Reset release is synchronized internally; the first RUN cycle occurs no earlier than 2 clk cycles after release.

Structure
REQ-029 A shared audio package holds the state enum (IDLE, RUN), the default CLK_DIV, the default DW, and the ovf_cnt width, which are common with the PWM playback block.
REQ-030 One sub-module, pdm_clkgen, contains the divider, mclk toggle, and fall strobe; the shift, count, write, and overflow logic stay in the top level.

Verification
REQ-031 CLK_DIV=2, DW=8, enable=1, full=0, micData driving 1,0,1,1,0,0,1,0 on successive strobes -> exactly one wr_en pulse with din=0xB2, one clk after the 8th strobe.
REQ-032 Continuous alternating micData for 16 mclk periods -> two wr_en pulses 16*CLK_DIV... exactly 8 mclk periods apart, each with din=0xAA or 0x55 depending on phase, and mclk period = 2*CLK_DIV clk cycles.
REQ-033 full=1 held through 3 word completions -> wr_en never asserts, overflow=1, ovf_cnt=3; then full=0 -> the next word is written and ovf_cnt stays 3.
REQ-034 full=1 held through 300 word completions -> ovf_cnt=255 (saturated).
REQ-035 enable dropped after 5 bits, then re-asserted -> no wr_en for the partial word; the next word contains only bits sampled after re-enable.
REQ-036 reset pulsed low for 1 clk mid-word -> all outputs at reset values immediately (asynchronously), and the first post-reset wr_en occurs only after 8 new strobes.

Source files
------------

// File: rtl/mic_pdm_capture_pkg.sv
// Shared audio definitions, common to PDM capture and PWM playback.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: run/idle state enum, default divider and word width, overflow
// counter width, and a saturating increment helper for that counter.
package mic_pdm_capture_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } audio_state_t;

  localparam int AUDIO_CLK_DIV = 25;
  localparam int AUDIO_DW      = 8;
  localparam int OVF_CNT_W     = 8;

  function automatic logic [OVF_CNT_W-1:0] sat_inc(input logic [OVF_CNT_W-1:0] v);
    return (v == '1) ? v : v + OVF_CNT_W'(1);
  endfunction

endpackage

// File: rtl/mic_pdm_capture_clkgen.sv
// Microphone bit-clock generator: divides clk down to a 50% duty mclk.
// Latency: first mclk rise CLK_DIV cycles after run rises; fall_stb is combinational.
// Backpressure: none; free-running while run=1, parked low with divider cleared otherwise.
// Ports: clk, reset (async active-low), run (1 = counting),
//        mclk (bit clock out), fall_stb (high in the clk cycle where mclk goes 1->0).
module pdm_clkgen
  import mic_pdm_capture_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic mclk,
  output logic fall_stb
);

  localparam logic [7:0] DIV_TC = 8'(CLK_DIV - 1);

  logic [7:0] div;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div  <= '0;
      mclk <= 1'b0;
    end else if (!run) begin
      div  <= '0;
      mclk <= 1'b0;
    end else if (div == DIV_TC) begin
      div  <= '0;
      mclk <= ~mclk;
    end else begin
      div <= div + 8'd1;
    end
  end

  // The cycle whose closing edge drives mclk low is the sample point.
  assign fall_stb = run && mclk && (div == DIV_TC);

endmodule

// File: rtl/mic_pdm_capture.sv
// PDM microphone capture: shifts synchronized mic bits into DW-bit words for a FIFO.
// Latency: word presented (wr_en) one clk after the mclk fall that samples its last bit.
// Backpressure: none; if full=1 in the wr_en cycle the word is dropped and counted.
// Ports: clk, reset (async active-low), enable (capture level), mclk (bit clock),
//        micData (async PDM in), din/wr_en (FIFO write), full (FIFO flag),
//        overflow/ledres (sticky drop flag), ovf_cnt (saturating drop count).
module mic_pdm_capture
  import mic_pdm_capture_pkg::*;
#(
  parameter int CLK_DIV = AUDIO_CLK_DIV,
  parameter int DW      = AUDIO_DW
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 mclk,
  input  logic                 micData,
  output logic [DW-1:0]        din,
  output logic                 wr_en,
  input  logic                 full,
  output logic                 overflow,
  output logic [OVF_CNT_W-1:0] ovf_cnt,
  output logic                 ledres
);

  localparam int              CW       = (DW > 1) ? $clog2(DW) : 1;
  localparam logic [CW-1:0]   LAST_BIT = CW'(DW - 1);

  audio_state_t  state;
  logic [1:0]    rst_pipe;   // fills with 1s after reset release; RUN waits for it
  logic [1:0]    mic_sync;
  logic [DW-1:0] shift;
  logic [CW-1:0] bitcnt;
  logic          word_pend;  // din holds a completed word this cycle
  logic          fall_stb;
  logic          run;

  assign run = (state == RUN);

  pdm_clkgen #(
    .CLK_DIV (CLK_DIV)
  ) u_clkgen (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .mclk     (mclk),
    .fall_stb (fall_stb)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mic_sync <= '0;
      rst_pipe <= '0;
    end else begin
      mic_sync <= {mic_sync[0], micData};
      rst_pipe <= {rst_pipe[0], 1'b1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      shift     <= '0;
      bitcnt    <= '0;
      din       <= '0;
      word_pend <= 1'b0;
      overflow  <= 1'b0;
      ovf_cnt   <= '0;
    end else begin
      word_pend <= 1'b0;

      // The FIFO decides in the presentation cycle; a refused word is gone.
      if (word_pend && full) begin
        overflow <= 1'b1;
        ovf_cnt  <= sat_inc(ovf_cnt);
      end

      case (state)
        IDLE: begin
          bitcnt <= '0;
          if (enable && rst_pipe[1]) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (fall_stb) begin
            if (!enable) begin
              // Leave on a fall so mclk parks low; the partial word is abandoned.
              state  <= IDLE;
              bitcnt <= '0;
            end else begin
              shift <= {shift[DW-2:0], mic_sync[1]};
              if (bitcnt == LAST_BIT) begin
                bitcnt    <= '0;
                din       <= {shift[DW-2:0], mic_sync[1]};
                word_pend <= 1'b1;
              end else begin
                bitcnt <= bitcnt + CW'(1);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobe is gated by full in the same cycle so a refused word never writes.
  assign wr_en  = word_pend & ~full;
  assign ledres = overflow;

endmodule
